// File: rtl/exec_seq_ctrl_if.sv
// Bus handshake bundle between the execution sequencer and the IFU/LSU.
// master = sequencer side, slave = fetch/load-store unit side.
interface exec_seq_ctrl_if;
    logic ifu_req_valid;
    logic ifu_req_ready;
    logic ifu_resp_valid;
    logic instr_latch;
    logic lsu_req_valid;
    logic lsu_req_wen;
    logic lsu_req_ready;
    logic lsu_resp_valid;

    modport master (
        output ifu_req_valid, instr_latch, lsu_req_valid, lsu_req_wen,
        input  ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid
    );

    modport slave (
        input  ifu_req_valid, instr_latch, lsu_req_valid, lsu_req_wen,
        output ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid
    );
endinterface

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, execute, optional memory access, commit.
// Optional bus wait timeout enabled by defining SEQ_TIMEOUT_EN.
module exec_seq_ctrl #(
    parameter int CNT_W       = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    exec_seq_ctrl_if.master     bus,
    input  logic                dec_mem_valid,
    input  logic                dec_mem_wen,
    input  logic                dec_ebreak,
    output logic                commit,
    output logic                halted,
    output logic                bus_err,
    output logic [2:0]          state_o,
    output logic [CNT_W-1:0]    retire_cnt
);

    typedef enum logic [2:0] {
        F_REQ  = 3'd0,
        F_WAIT = 3'd1,
        EXEC   = 3'd2,
        M_REQ  = 3'd3,
        M_WAIT = 3'd4,
        COMMIT = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t state, state_next;
    logic   wen_q;
    logic   timeout;
    logic   in_wait;

    assign state_o         = state;
    assign halted          = (state == HALT);
    assign bus.lsu_req_wen = wen_q;
    assign in_wait         = (state == F_REQ) || (state == F_WAIT) ||
                             (state == M_REQ) || (state == M_WAIT);

`ifdef SEQ_TIMEOUT_EN
    localparam int WAIT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              bus_err_q;
`endif

    always_comb begin
        state_next         = state;
        timeout            = 1'b0;
        bus.ifu_req_valid  = 1'b0;
        bus.instr_latch    = 1'b0;
        bus.lsu_req_valid  = 1'b0;
        commit             = 1'b0;
        case (state)
            F_REQ: begin
                bus.ifu_req_valid = 1'b1;
                if (bus.ifu_req_ready) state_next = F_WAIT;
            end
            F_WAIT: begin
                if (bus.ifu_resp_valid) begin
                    bus.instr_latch = 1'b1;
                    state_next      = EXEC;
                end
            end
            EXEC: begin
                if (dec_ebreak)         state_next = HALT;
                else if (dec_mem_valid) state_next = M_REQ;
                else                    state_next = COMMIT;
            end
            M_REQ: begin
                bus.lsu_req_valid = 1'b1;
                if (bus.lsu_req_ready) state_next = M_WAIT;
            end
            M_WAIT: begin
                if (bus.lsu_resp_valid) state_next = COMMIT;
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = F_REQ;
            end
            HALT:    state_next = HALT;
            default: state_next = F_REQ;
        endcase
`ifdef SEQ_TIMEOUT_EN
        // A handshake in the final allowed cycle still wins over the timeout.
        if (in_wait && (state_next == state) && (wait_cnt == WAIT_LAST)) begin
            state_next = HALT;
            timeout    = 1'b1;
        end
`endif
        // Reset drops any outstanding request and suppresses pulses.
        if (rst) begin
            bus.ifu_req_valid = 1'b0;
            bus.instr_latch   = 1'b0;
            bus.lsu_req_valid = 1'b0;
            commit            = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= F_REQ;
            wen_q      <= 1'b0;
            retire_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == EXEC && !dec_ebreak && dec_mem_valid)
                wen_q <= dec_mem_wen;
            if (commit)
                retire_cnt <= retire_cnt + 1'b1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_next != state)
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout)
                bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC == 0) ^ in_wait ^ timeout;
    assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Directed self-checking bench for exec_seq_ctrl (narrow retire counter to reach wrap).
// Define SEQ_TIMEOUT_EN to also exercise the bus wait timeout.
module tb_exec_seq_ctrl;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             dec_mem_valid;
    logic             dec_mem_wen;
    logic             dec_ebreak;
    logic             commit;
    logic             halted;
    logic             bus_err;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retire_cnt;
    int               n_checks;
    int               n_fail;

    exec_seq_ctrl_if bus ();

    exec_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.master),
        .dec_mem_valid (dec_mem_valid),
        .dec_mem_wen   (dec_mem_wen),
        .dec_ebreak    (dec_ebreak),
        .commit        (commit),
        .halted        (halted),
        .bus_err       (bus_err),
        .state_o       (state_o),
        .retire_cnt    (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ir, input logic iresp, input logic mv,
                                 input logic mw, input logic eb, input logic lr,
                                 input logic lresp);
        bus.ifu_req_ready  = ir;
        bus.ifu_resp_valid = iresp;
        dec_mem_valid      = mv;
        dec_mem_wen        = mw;
        dec_ebreak         = eb;
        bus.lsu_req_ready  = lr;
        bus.lsu_resp_valid = lresp;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Plain ALU instruction with every handshake immediate; retire count checked after.
    task automatic runAlu(input logic [63:0] exp_cnt);
        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("alu_commit", commit, 1); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu_retire", retire_cnt, exp_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        checkOutput("rst_state", state_o, 0);
        checkOutput("rst_retire", retire_cnt, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_buserr", bus_err, 0);
        checkOutput("rst_commit", commit, 0);
        rst = 1'b0;

        // ALU instruction, all immediate: commit in 4th cycle after release
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("t1_freq_state", state_o, 0);
        checkOutput("t1_ifu_valid", bus.ifu_req_valid, 1);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("t1_fwait_state", state_o, 1);
        checkOutput("t1_latch", bus.instr_latch, 1);
        checkOutput("t1_ifu_valid_lo", bus.ifu_req_valid, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_exec_state", state_o, 2);
        checkOutput("t1_exec_commit", commit, 0);
        tick();
        checkOutput("t1_commit_state", state_o, 5);
        checkOutput("t1_commit", commit, 1);
        checkOutput("t1_retire_pre", retire_cnt, 0);
        tick();
        checkOutput("t1_retire", retire_cnt, 1);
        checkOutput("t1_commit_lo", commit, 0);

        // Load with lsu_req_ready delayed three cycles
        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, (i == 3), 0);
            checkOutput("t2_lsu_valid", bus.lsu_req_valid, 1);
            checkOutput("t2_lsu_wen", bus.lsu_req_wen, 0);
            checkOutput("t2_mreq_state", state_o, 3);
            tick();
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("t2_mwait_state", state_o, 4);
        checkOutput("t2_lsu_valid_lo", bus.lsu_req_valid, 0);
        checkOutput("t2_spurious_latch", bus.instr_latch, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("t2_mwait_hold", state_o, 4);
        tick();
        checkOutput("t2_commit", commit, 1);
        tick();
        checkOutput("t2_retire", retire_cnt, 2);

        // Fetch request held while not accepted
        applyStimulus(0, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("stall_state", state_o, 0);
        checkOutput("stall_ifu_valid", bus.ifu_req_valid, 1);

        // Store then ALU back to back
        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 1, 1, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("t3_store_wen", bus.lsu_req_wen, 1);
        checkOutput("t3_store_valid", bus.lsu_req_valid, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1); tick();
        checkOutput("t3_store_commit", commit, 1);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_alu_no_lsu", bus.lsu_req_valid, 0);
        tick(); tick();
        checkOutput("t3_retire", retire_cnt, 4);

        // Reset while waiting for the load response
        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 1, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("t4_mwait_state", state_o, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_state", state_o, 0);
        checkOutput("t4_lsu_valid", bus.lsu_req_valid, 0);
        checkOutput("t4_retire", retire_cnt, 0);
        checkOutput("t4_commit", commit, 0);

        // Retire counter wraps silently after 2^CNT_W commits
        for (int k = 1; k <= 8; k++) runAlu(k % 8);
        checkOutput("wrap_buserr", bus_err, 0);

        // ebreak halts without commit; later responses ignored
        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        checkOutput("t5_exec_commit", commit, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 1, 0, 1, 1);
            checkOutput("t5_state", state_o, 6);
            checkOutput("t5_halted", halted, 1);
            checkOutput("t5_commit", commit, 0);
            checkOutput("t5_ifu_valid", bus.ifu_req_valid, 0);
            checkOutput("t5_latch", bus.instr_latch, 0);
            checkOutput("t5_lsu_valid", bus.lsu_req_valid, 0);
            tick();
        end
        checkOutput("t5_retire", retire_cnt, 0);
        checkOutput("t5_buserr", bus_err, 0);

`ifdef SEQ_TIMEOUT_EN
        // Fetch response never arrives: error after 16 cycles in F_WAIT
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            checkOutput("to_fwait", state_o, 1);
            checkOutput("to_buserr_lo", bus_err, 0);
            tick();
        end
        checkOutput("to_state", state_o, 6);
        checkOutput("to_buserr", bus_err, 1);
        checkOutput("to_halted", halted, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
